// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite register file slave: response codes and channel FSM states.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        WR_ACCEPT = 1'b0,
        WR_RESP   = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_ACCEPT = 1'b0,
        RD_DATA   = 1'b1
    } rd_state_t;

    // Width of a register index; a single register still needs one index bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4lite_reg_file.sv
// Register storage: byte-strobed write port, combinational read port, one-cycle write pulses.
module axi4lite_reg_file
    import axi4lite_pkg::*;
#(
    parameter int unsigned                     DATA_WIDTH = 32,
    parameter int unsigned                     NUM_REGS   = 16,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL  = '0,
    parameter int unsigned                     IDX_W      = idx_width(NUM_REGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           we_i,
    input  logic [IDX_W-1:0]               widx_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
    input  logic [IDX_W-1:0]               ridx_i,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]            pulse_q, pulse_d;

    // Merge enabled bytes into the addressed register and flag it for one cycle.
    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (we_i && (widx_i == IDX_W'(i))) begin
                pulse_d[i] = 1'b1;
                for (int unsigned b = 0; b < NumBytes; b++) begin
                    if (wstrb_i[b]) begin
                        regs_d[i*DATA_WIDTH + b*8 +: 8] = wdata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Storage and pulse state; reset restores the configured register values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q  <= RESET_VAL;
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    // Read mux; an index with no matching register returns zero.
    always_comb begin
        rdata_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ridx_i == IDX_W'(i)) begin
                rdata_o = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign regs_o     = regs_q;
    assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave front end: independent write/read FSMs, AW/W capture, address and RO decode.
module axi4lite_regfile_slave
    import axi4lite_pkg::*;
#(
    parameter int unsigned                     ADDR_WIDTH = 32,
    parameter int unsigned                     DATA_WIDTH = 32,
    parameter int unsigned                     NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]             RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
    input  logic                           A_CLK,
    input  logic                           A_RSTn,
    input  logic                           AW_VALID,
    output logic                           AW_READY,
    input  logic [ADDR_WIDTH-1:0]          AW_ADDR,
    input  logic                           W_VALID,
    output logic                           W_READY,
    input  logic [DATA_WIDTH-1:0]          W_DATA,
    input  logic [DATA_WIDTH/8-1:0]        W_STRB,
    output logic                           B_VALID,
    input  logic                           B_READY,
    output logic [1:0]                     B_RESP,
    input  logic                           AR_VALID,
    output logic                           AR_READY,
    input  logic [ADDR_WIDTH-1:0]          AR_ADDR,
    output logic                           R_VALID,
    input  logic                           R_READY,
    output logic [DATA_WIDTH-1:0]          R_DATA,
    output logic [1:0]                     R_RESP,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned Offs  = $clog2(StrbW);
    localparam int unsigned IdxW  = idx_width(NUM_REGS);
    localparam int unsigned FullW = ADDR_WIDTH - Offs;
    localparam logic [FullW-1:0] NumRegsA = FullW'(NUM_REGS);

    wr_state_t               wr_state_q, wr_state_d;
    rd_state_t               rd_state_q, rd_state_d;
    logic                    active_q;
    logic                    aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [StrbW-1:0]        w_strb_q, w_strb_d;
    resp_t                   b_resp_q, b_resp_d;
    logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;
    resp_t                   r_resp_q, r_resp_d;

    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [FullW-1:0]        wr_idx_full, rd_idx_full;
    logic [IdxW-1:0]         wr_idx, rd_idx;
    logic                    wr_in_range, wr_ro, rd_in_range, rf_we;
    logic [DATA_WIDTH-1:0]   wr_data, rf_rdata;
    logic [StrbW-1:0]        wr_strb;
    logic                    addr_lsb_unused;

    assign aw_hs = AW_VALID & AW_READY;
    assign w_hs  = W_VALID & W_READY;
    assign b_hs  = B_VALID & B_READY;
    assign ar_hs = AR_VALID & AR_READY;
    assign r_hs  = R_VALID & R_READY;

    // A payload arriving this cycle bypasses its capture register so a same-edge pair commits.
    assign wr_addr = aw_got_q ? aw_addr_q : AW_ADDR;
    assign wr_data = w_got_q ? w_data_q : W_DATA;
    assign wr_strb = w_got_q ? w_strb_q : W_STRB;
    assign commit  = (wr_state_q == WR_ACCEPT) && (aw_got_q || aw_hs) && (w_got_q || w_hs);

    // Byte-offset bits never select anything.
    assign addr_lsb_unused = ^{wr_addr[Offs-1:0], AR_ADDR[Offs-1:0]};

    assign wr_idx_full = wr_addr[ADDR_WIDTH-1:Offs];
    assign wr_in_range = wr_idx_full < NumRegsA;
    assign wr_idx      = wr_idx_full[IdxW-1:0];
    assign wr_ro       = RO_MASK[wr_idx];
    assign rf_we       = commit && wr_in_range && !wr_ro;

    assign rd_idx_full = AR_ADDR[ADDR_WIDTH-1:Offs];
    assign rd_in_range = rd_idx_full < NumRegsA;
    assign rd_idx      = rd_idx_full[IdxW-1:0];

    axi4lite_reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RESET_VAL  (RESET_VAL),
        .IDX_W      (IdxW)
    ) u_reg_file (
        .clk_i      (A_CLK),
        .rst_ni     (A_RSTn),
        .we_i       (rf_we),
        .widx_i     (wr_idx),
        .wdata_i    (wr_data),
        .wstrb_i    (wr_strb),
        .ridx_i     (rd_idx),
        .rdata_o    (rf_rdata),
        .regs_o     (reg_out),
        .wr_pulse_o (wr_pulse)
    );

    // State registers; active_q keeps every READY low while and just after reset.
    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            wr_state_q <= WR_ACCEPT;
            rd_state_q <= RD_ACCEPT;
            active_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            active_q   <= 1'b1;
        end
    end

    // Next-state logic for both channel FSMs.
    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        case (wr_state_q)
            WR_ACCEPT: if (commit) wr_state_d = WR_RESP;
            WR_RESP:   if (b_hs)   wr_state_d = WR_ACCEPT;
        endcase
        case (rd_state_q)
            RD_ACCEPT: if (ar_hs) rd_state_d = RD_DATA;
            RD_DATA:   if (r_hs)  rd_state_d = RD_ACCEPT;
        endcase
    end

    // Handshake outputs decoded from state; responses come straight from their registers.
    always_comb begin
        AW_READY = active_q && (wr_state_q == WR_ACCEPT) && !aw_got_q;
        W_READY  = active_q && (wr_state_q == WR_ACCEPT) && !w_got_q;
        B_VALID  = (wr_state_q == WR_RESP);
        B_RESP   = b_resp_q;
        AR_READY = active_q && (rd_state_q == RD_ACCEPT);
        R_VALID  = (rd_state_q == RD_DATA);
        R_DATA   = r_data_q;
        R_RESP   = r_resp_q;
    end

    // Capture flags/payloads and the registered write/read responses.
    always_comb begin
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_resp_d  = b_resp_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        if (aw_hs) begin
            aw_got_d  = 1'b1;
            aw_addr_d = AW_ADDR;
        end
        if (w_hs) begin
            w_got_d  = 1'b1;
            w_data_d = W_DATA;
            w_strb_d = W_STRB;
        end
        if (commit) begin
            b_resp_d = !wr_in_range ? DECERR : (wr_ro ? SLVERR : OKAY);
        end
        if (b_hs) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
        end
        if (ar_hs) begin
            r_data_d = rd_in_range ? rf_rdata : '0;
            r_resp_d = rd_in_range ? OKAY : DECERR;
        end
    end

    // Payload and response registers; reset drops any half-captured write.
    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= OKAY;
            r_data_q  <= '0;
            r_resp_q  <= OKAY;
        end else begin
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_resp_q  <= b_resp_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
        end
    end

endmodule

// File: doc/axi4lite_regfile_slave.md
Name: axi4lite_regfile_slave

Overview:
Parametrised AXI4-Lite slave with an internal register file of NUM_REGS words, each DATA_WIDTH bits wide.
- Read and write channels run independently through separate FSMs.
- AW and W are accepted in any order.
- WSTRB byte enables are honoured.
- Responses are spec-correct: OKAY, SLVERR for writes to read-only registers, DECERR for out-of-range addresses.
- Register contents are exported flat to the surrounding design, together with per-register write strobes.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, AXI data and register width; 32 or 64 only.
NUM_REGS, 16, number of registers, 1..256.
RO_MASK, {NUM_REGS{1'b0}}, bit i set makes register i read-only for AXI writes.
RESET_VAL, {NUM_REGS*DATA_WIDTH{1'b0}}, per-register reset value, register i at slice i.

Ports:
A_CLK  in  1  clock
A_RSTn  in  1  reset, asynchronous, active-low
AW_VALID  in  1  write address valid
AW_READY  out  1  write address ready
AW_ADDR  in  ADDR_WIDTH  write byte address
W_VALID  in  1  write data valid
W_READY  out  1  write data ready
W_DATA  in  DATA_WIDTH  write data
W_STRB  in  DATA_WIDTH/8  byte enables
B_VALID  out  1  write response valid
B_READY  in  1  write response ready
B_RESP  out  2  write response
AR_VALID  in  1  read address valid
AR_READY  out  1  read address ready
AR_ADDR  in  ADDR_WIDTH  read byte address
R_VALID  out  1  read data valid
R_READY  in  1  read data ready
R_DATA  out  DATA_WIDTH  read data
R_RESP  out  2  read response
reg_out  out  NUM_REGS*DATA_WIDTH  current register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  out  NUM_REGS  one-cycle pulse, bit i set on the cycle after register i is written

Behaviour:
Reset (async assert, synchronous deassert handled upstream):
- Both FSMs go to idle.
- Capture flags clear.
- All READY and VALID outputs are 0; B_RESP, R_RESP and R_DATA are 0; wr_pulse is 0.
- Registers load RESET_VAL.
- Reset mid-transaction abandons it; no partial write is committed.

Address decode:
- idx = addr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
- idx >= NUM_REGS means out of range.

Write FSM, states WR_ACCEPT and WR_RESP:
- WR_ACCEPT: AW_READY = !aw_got and W_READY = !w_got.
- Each handshake latches its payload and sets its flag. The handshakes may occur in the same cycle or in either order.
- On the edge of the later handshake (or the shared edge), the write commits and the FSM moves to WR_RESP. B_VALID is high from the next cycle.
- A commit updates each byte b of register idx where W_STRB[b]=1, and sets wr_pulse[idx] for exactly one cycle.
- Out of range: B_RESP=2'b11 (DECERR), no update, no pulse.
- RO_MASK[idx]=1: B_RESP=2'b10 (SLVERR), no update, no pulse.
- Otherwise B_RESP=2'b00 (OKAY), including when W_STRB=0 (no bytes change; pulse still fires).
- WR_RESP: B_VALID and B_RESP are held stable until B_READY. On that handshake the flags clear and the FSM returns to WR_ACCEPT. Minimum write turnaround is 2 cycles.

Read FSM, states RD_ACCEPT and RD_DATA:
- RD_ACCEPT: AR_READY=1.
- On the AR handshake edge, R_DATA and R_RESP are registered and the FSM moves to RD_DATA. R_VALID is high the next cycle.
- Out of range: R_DATA=0, R_RESP=DECERR. Otherwise R_DATA is the register value and R_RESP=OKAY.
- RD_DATA: R_VALID, R_DATA and R_RESP are held stable until R_READY, then the FSM returns to RD_ACCEPT.

Concurrency:
- The read and write paths are fully independent; there is no arbitration.
- If a write commit and an AR handshake fall on the same edge to the same register, the read returns the pre-write value.
- reg_out reflects a commit from the next cycle.

Decomposition:
- Shared package axi4lite_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - wr_state_t (WR_ACCEPT, WR_RESP) and rd_state_t (RD_ACCEPT, RD_DATA).
- One sub-module, axi4lite_reg_file. It holds the storage, strobed write, one-cycle wr_pulse, RESET_VAL, and a combinational read port.
- The top level holds both FSMs, the capture registers, and address/RO decode.

Test Plan:
1. Reset, then AW(0x08) and W(0xDEADBEEF, STRB=4'hF) in the same cycle -> B_VALID one cycle later with B_RESP=OKAY; wr_pulse[2] high for exactly 1 cycle; read of 0x08 returns 0xDEADBEEF with OKAY.
2. W issued 3 cycles before AW(0x04), STRB=4'b0101, data 0x11223344, over reset value 0 -> register 1 reads 0x00220044.
3. Write to 0x40 with NUM_REGS=16 -> B_RESP=DECERR and no register changes; read of 0x40 -> R_DATA=0, R_RESP=DECERR.
4. RO_MASK bit 3 set, write 0x0C -> B_RESP=SLVERR, register 3 keeps RESET_VAL, wr_pulse stays 0.
5. B_READY held low 5 cycles, and R_READY held low likewise -> B_VALID/B_RESP and R_VALID/R_DATA held stable throughout; AW_READY/W_READY stay low until B handshake; AR_READY stays low until R handshake.
6. Same-edge write of 0x5 to reg 0 (old value 0x1) and AR 0x00 -> R_DATA=0x1; next read returns 0x5. Separately, assert A_RSTn low while in WR_RESP -> all outputs zero immediately and registers back to RESET_VAL.
